// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request and result handshake.
// Most ops finish in one cycle; MUL and DIV iterate one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flg_q, flg_d;
    logic               div_q, div_d;

    logic [WIDTH:0]     sum, dif;
    logic [WIDTH-1:0]   s_res;
    logic               s_carry, s_err;
    logic               iter;

    logic [WIDTH:0]     m_sum, d_sh, d_sub;
    logic [2*WIDTH-1:0] it_nxt;

    // Single-cycle datapath, evaluated on the live request operands
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        s_res   = '0;
        s_carry = 1'b0;
        s_err   = 1'b0;
        case (opcode)
            4'b0000: begin
                s_res   = sum[WIDTH-1:0];
                s_carry = sum[WIDTH];
            end
            4'b0001: begin
                s_res   = dif[WIDTH-1:0];
                s_carry = dif[WIDTH];
            end
            // Only taken as a single-cycle op when the divisor is zero
            4'b0011: s_err = 1'b1;
            4'b0100: s_res = {a[WIDTH-2:0], a[WIDTH-1]};
            4'b0101: s_res = {a[0], a[WIDTH-1:1]};
            4'b0110: begin
                if (a == '0) begin
                    s_res = '1;
                    s_err = 1'b1;
                end else begin
                    for (int i = 0; i < WIDTH; i++)
                        if (a[i]) s_res = WIDTH'(i);
                end
            end
            4'b0111: s_res = a ^ (a >> 1);
            4'b1000: begin
                if (sum[WIDTH]) begin
                    s_res   = '1;
                    s_carry = 1'b1;
                end else begin
                    s_res = sum[WIDTH-1:0];
                end
            end
            4'b1001: begin
                for (int i = 0; i < WIDTH; i++)
                    s_res = s_res + WIDTH'(a[i]);
            end
            4'b1010: s_res = a & b;
            4'b1011: s_res = a | b;
            4'b1100: s_res = ~a;
            4'b1101: s_res = a ^ b;
            4'b1110: s_res = {{(WIDTH-1){1'b0}}, a > b};
            4'b1111: s_res = {{(WIDTH-1){1'b0}}, a == b};
            default: ;
        endcase
    end

    assign iter = (opcode == OP_MUL) || (opcode == OP_DIV && b != '0);

    // One iteration step: shift-add multiply or restoring divide on p_q
    always_comb begin
        m_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
              + {1'b0, {WIDTH{p_q[0]}} & a_q};
        d_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        d_sub = d_sh - {1'b0, b_q};
        if (div_q) begin
            if (d_sub[WIDTH])
                it_nxt = {d_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            else
                it_nxt = {d_sub[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            it_nxt = {m_sum, p_q[WIDTH-1:1]};
        end
    end

    // Handshake FSM and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        div_d   = div_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    if (iter) begin
                        state_d = S_EXEC;
                        cnt_d   = '0;
                        div_d   = (opcode == OP_DIV);
                        p_d     = {{WIDTH{1'b0}}, (opcode == OP_DIV) ? a : b};
                    end else begin
                        state_d = S_DONE;
                        res_d   = s_res;
                        flg_d   = {s_res == '0, s_carry, s_res[WIDTH-1], s_err};
                    end
                end
            end
            S_EXEC: begin
                p_d   = it_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    res_d   = it_nxt[WIDTH-1:0];
                    flg_d   = {it_nxt[WIDTH-1:0] == '0,
                               ~div_q & (|it_nxt[2*WIDTH-1:WIDTH]),
                               it_nxt[WIDTH-1], 1'b0};
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            div_q   <= div_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_EXEC);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign flags     = flg_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed bench for seq_alu with a cycle-level reference model.
// Main instance is WIDTH=8; small WIDTH=4 and WIDTH=16 instances get spot checks.
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0] opcode = '0;
    logic in_ready, out_valid, busy;
    logic [W-1:0] result;
    logic [3:0] flags;

    logic v4 = 1'b0, r4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, op4 = '0;
    logic ir4, ov4, bz4;
    logic [3:0] res4, f4;

    logic v16 = 1'b0, r16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0] op16 = '0;
    logic ir16, ov16, bz16;
    logic [15:0] res16;
    logic [3:0] f16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    seq_alu #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(ir4),
        .a(a4), .b(b4), .opcode(op4),
        .out_valid(ov4), .out_ready(r4),
        .result(res4), .flags(f4), .busy(bz4)
    );

    seq_alu #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(ir16),
        .a(a16), .b(b16), .opcode(op16),
        .out_valid(ov16), .out_ready(r16),
        .result(res16), .flags(f16), .busy(bz16)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: {result, zero, carry, sign, error} from plain arithmetic
    function automatic logic [11:0] ref_op(input logic [3:0] op,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
        int xi, yi, r, n, v;
        logic c, e;
        logic [7:0] rr;
        xi = int'(x);
        yi = int'(y);
        c = 1'b0;
        e = 1'b0;
        r = 0;
        case (op)
            4'h0: begin r = xi + yi; c = (r > 255); end
            4'h1: begin r = xi - yi; c = (xi < yi); end
            4'h2: begin r = xi * yi; c = (r > 255); end
            4'h3: begin
                if (yi == 0) begin r = 0; e = 1'b1; end
                else r = xi / yi;
            end
            4'h4: r = (xi * 2) + (xi / 128);
            4'h5: r = (xi / 2) + (xi % 2) * 128;
            4'h6: begin
                if (xi == 0) begin r = 255; e = 1'b1; end
                else begin
                    n = 0;
                    v = xi;
                    while (v > 1) begin v = v / 2; n++; end
                    r = n;
                end
            end
            4'h7: r = xi ^ (xi / 2);
            4'h8: begin
                r = xi + yi;
                if (r > 255) begin r = 255; c = 1'b1; end
            end
            4'h9: r = $countones(x);
            4'hA: r = xi & yi;
            4'hB: r = xi | yi;
            4'hC: r = 255 - xi;
            4'hD: r = xi ^ yi;
            4'hE: r = (xi > yi) ? 1 : 0;
            default: r = (xi == yi) ? 1 : 0;
        endcase
        rr = r[7:0];
        return {rr, rr == 8'h00, c, rr[7], e};
    endfunction

    // Cycle-level model of the handshake: 0 idle, 1 iterating, 2 result held
    int m_phase = 0;
    int m_left = 0;
    logic [11:0] m_pend = '0;
    logic [11:0] m_out = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_out   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend <= ref_op(opcode, a, b);
                    if (opcode == 4'h2 || (opcode == 4'h3 && b != 0)) begin
                        m_phase <= 1;
                        m_left  <= W;
                    end else begin
                        m_phase <= 2;
                        m_out   <= ref_op(opcode, a, b);
                    end
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_out   <= m_pend;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
        chk("cmp_busy", {31'd0, busy}, {31'd0, m_phase == 1});
        chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
        if (m_phase == 2) begin
            chk("cmp_result", {24'd0, result}, {24'd0, m_out[11:4]});
            chk("cmp_flags", {28'd0, flags}, {28'd0, m_out[3:0]});
        end
    end

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
        logic [4:0] lat;
    } vec_t;

    vec_t vt [22] = '{
        '{4'h0, 8'hF0, 8'h20, 8'h10, 4'h4, 5'd1},
        '{4'h2, 8'h10, 8'h11, 8'h10, 4'h4, 5'd9},
        '{4'h3, 8'h64, 8'h07, 8'h0E, 4'h0, 5'd9},
        '{4'h3, 8'h64, 8'h00, 8'h00, 4'h9, 5'd1},
        '{4'h1, 8'h05, 8'h07, 8'hFE, 4'h6, 5'd1},
        '{4'h4, 8'h81, 8'h00, 8'h03, 4'h0, 5'd1},
        '{4'h5, 8'h01, 8'h00, 8'h80, 4'h2, 5'd1},
        '{4'h6, 8'h28, 8'h00, 8'h05, 4'h0, 5'd1},
        '{4'h6, 8'h00, 8'h00, 8'hFF, 4'h3, 5'd1},
        '{4'h7, 8'hB4, 8'h00, 8'hEE, 4'h2, 5'd1},
        '{4'h8, 8'hC0, 8'h50, 8'hFF, 4'h6, 5'd1},
        '{4'h9, 8'hB7, 8'h00, 8'h06, 4'h0, 5'd1},
        '{4'hA, 8'hF0, 8'h3C, 8'h30, 4'h0, 5'd1},
        '{4'hB, 8'h0F, 8'hF0, 8'hFF, 4'h2, 5'd1},
        '{4'hC, 8'hFF, 8'h00, 8'h00, 4'h8, 5'd1},
        '{4'hD, 8'hAA, 8'hAA, 8'h00, 4'h8, 5'd1},
        '{4'hE, 8'h05, 8'h03, 8'h01, 4'h0, 5'd1},
        '{4'hE, 8'h03, 8'h05, 8'h00, 4'h8, 5'd1},
        '{4'hF, 8'h07, 8'h07, 8'h01, 4'h0, 5'd1},
        '{4'h2, 8'hFF, 8'hFF, 8'h01, 4'h4, 5'd9},
        '{4'h3, 8'hFF, 8'h01, 8'hFF, 4'h2, 5'd9},
        '{4'h0, 8'h80, 8'h80, 8'h00, 4'hC, 5'd1}
    };

    task automatic do_op(input vec_t v, input int idx);
        int n;
        @(posedge clk);
        #2;
        opcode = v.op;
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        a = ~v.a;
        b = 8'h00;
        opcode = 4'h0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk($sformatf("op%0d_latency", idx), n, {27'd0, v.lat});
        chk($sformatf("op%0d_result", idx), {24'd0, result}, {24'd0, v.r});
        chk($sformatf("op%0d_flags", idx), {28'd0, flags}, {28'd0, v.f});
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        chk($sformatf("op%0d_back_idle", idx), {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run4(input logic [3:0] op, input logic [3:0] x,
                        input logic [3:0] y, input logic [3:0] er,
                        input logic [3:0] ef, input string nm);
        int n;
        @(posedge clk);
        #2;
        op4 = op;
        a4 = x;
        b4 = y;
        v4 = 1'b1;
        @(posedge clk);
        #2;
        v4 = 1'b0;
        n = 1;
        while (!ov4 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({nm, "_latency"}, n, 32'd1);
        chk({nm, "_result"}, {28'd0, res4}, {28'd0, er});
        chk({nm, "_flags"}, {28'd0, f4}, {28'd0, ef});
        r4 = 1'b1;
        @(posedge clk);
        #2;
        r4 = 1'b0;
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er,
                         input logic [3:0] ef, input int lat,
                         input string nm);
        int n;
        @(posedge clk);
        #2;
        op16 = op;
        a16 = x;
        b16 = y;
        v16 = 1'b1;
        @(posedge clk);
        #2;
        v16 = 1'b0;
        n = 1;
        while (!ov16 && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_result"}, {16'd0, res16}, {16'd0, er});
        chk({nm, "_flags"}, {28'd0, f16}, {28'd0, ef});
        r16 = 1'b1;
        @(posedge clk);
        #2;
        r16 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 22; i++)
            chk($sformatf("model_pin%0d", i),
                {20'd0, ref_op(vt[i].op, vt[i].a, vt[i].b)},
                {20'd0, vt[i].r, vt[i].f});

        for (int i = 0; i < 22; i++)
            do_op(vt[i], i);

        // Backpressure: result held, new requests ignored
        @(posedge clk);
        #2;
        opcode = 4'h0;
        a = 8'h03;
        b = 8'h04;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        opcode = 4'hD;
        a = 8'hFF;
        b = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            chk("bp_result", {24'd0, result}, 32'h07);
            chk("bp_flags", {28'd0, flags}, 32'h0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the third EXEC cycle of a multiply
        @(posedge clk);
        #2;
        opcode = 4'h2;
        a = 8'h10;
        b = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("mrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_result", {24'd0, result}, 32'd0);
        chk("mrst_flags", {28'd0, flags}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #2;
            chk("mrst_no_out_valid", {31'd0, out_valid}, 32'd0);
            chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        end

        run4(4'h8, 4'hF, 4'h1, 4'hF, 4'h6, "w4_satadd");
        run4(4'h6, 4'h0, 4'h0, 4'hF, 4'h3, "w4_hsb_zero");
        run16(4'h6, 16'h0000, 16'h0000, 16'hFFFF, 4'h3, 1, "w16_hsb_zero");
        run16(4'h8, 16'hFFF0, 16'h0020, 16'hFFFF, 4'h6, 1, "w16_satadd");
        run16(4'h2, 16'h0100, 16'h0100, 16'h0000, 4'hC, 17, "w16_mul");
        run16(4'h3, 16'hC350, 16'h00FA, 16'h00C8, 4'h0, 17, "w16_div");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port opcode  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  registered {zero, carry, sign, error}.
REQ-013 SHALL have port busy  output  1  high while an iterative operation runs.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; in_ready = (state==IDLE); busy = (state==EXEC); out_valid = (state==DONE).
REQ-015 SHALL accept a request when in_valid && in_ready, capturing a, b, opcode in that cycle; later input changes are ignored until the next accept.
REQ-016 SHALL complete single-cycle ops by IDLE->DONE: out_valid is asserted in the cycle after accept (latency 1).
REQ-017 SHALL execute MUL (0010) and DIV (0011, b!=0) as iterative ops: IDLE->EXEC, WIDTH cycles in EXEC, then DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-018 SHALL hold result, flags and out_valid stable in DONE until out_ready; on out_ready transition to IDLE (in_ready high in the next cycle).
REQ-019 SHALL implement opcodes: 0000 add; 0001 sub (A-B mod 2^WIDTH); 0010 mul (shift-add, low WIDTH bits); 0011 div (restoring, unsigned quotient); 0100 rotate left by 1; 0101 rotate right by 1; 0110 index of highest set bit of A; 0111 Gray code A^(A>>1); 1000 unsigned saturating add (clamps to all-ones); 1001 popcount of A; 1010 AND; 1011 OR; 1100 NOT A; 1101 XOR; 1110 A>B unsigned, 1 in bit 0; 1111 A==B, 1 in bit 0.
REQ-020 SHALL set zero = (result==0) and sign = result[WIDTH-1] for every opcode.
REQ-021 SHALL set carry: add = carry-out; sub = borrow (A<B); mul = any product bit above WIDTH-1 nonzero; satadd = saturation occurred; 0 otherwise.
REQ-022 SHALL handle DIV with b==0 as a single-cycle op: result = 0, error = 1, zero = 1, no EXEC entry.
REQ-023 SHALL for opcode 0110 with A==0 output result all-ones and error = 1; error = 0 for all other cases.
REQ-024 SHALL ignore in_valid while not in IDLE (no queueing, no overwrite of pending result).
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL zero-extend narrow results (index, popcount, compare) to WIDTH.

Reset
REQ-027 SHALL on rst asynchronously force state IDLE, result = 0, flags = 0, out_valid = 0, busy = 0, iteration counter = 0; in_ready = 1 once rst deasserts.
REQ-028 SHALL abort any EXEC/DONE operation on rst mid-operation; the aborted result is never presented.

Verification
REQ-029 SHALL cover WIDTH=8 add a=0xF0 b=0x20 -> result 0x10, flags carry=1 zero=0 sign=0, out_valid one cycle after accept.
REQ-030 SHALL cover WIDTH=8 mul a=0x10 b=0x11 -> result 0x10, carry=1; busy high 8 cycles, out_valid 9 cycles after accept.
REQ-031 SHALL cover div a=0x64 b=0x07 -> result 0x0E after WIDTH+1 cycles; div b=0 -> result 0, error=1, zero=1 at latency 1.
REQ-032 SHALL cover backpressure: out_ready low 5 cycles in DONE -> result/flags stable, in_ready low, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-033 SHALL cover rst asserted in 3rd EXEC cycle of mul -> all outputs 0 immediately, in_ready 1 after release, no out_valid.
REQ-034 SHALL cover WIDTH=4 and WIDTH=16 builds: satadd 0xF+0x1 (W=4) -> 0xF carry=1; highest-bit index a=0 -> all-ones, error=1.
